// File: rtl/rhs_spi_responder.sv
// -----------------------------------------------------------------------------
// rhs_spi_responder
//
// Fabric-clock model of an RHS2116 SPI responder for one headstage chip.
// SCLK/CS/MOSI are oversampled (clk >= 4x SCLK). Each 32-bit frame is decoded
// when CS rises. Its response comes back on MISO two frames later, which
// matches the chip's pipeline.
//
// Parameters
//   STARTING_SEED  base value added to every CONVERT sample (per-port offset)
//   NUM_REGS       number of writable registers, addresses 0..NUM_REGS-1
//
// Ports
//   clk          fabric clock
//   rst          synchronous, active-high reset
//   SCLK         SPI clock, CPOL=0 / CPHA=0, asynchronous to clk
//   CS           active-low frame select, asynchronous
//   MOSI         command bits, MSB first, asynchronous
//   MISO         response bits, MSB first, registered
//   frame_count  number of valid (32-bit) frames, wraps at 0xFFFF
//   frame_error  one-cycle pulse when a frame ends with bit count != 32
//   last_cmd     most recent valid command word
// -----------------------------------------------------------------------------
module rhs_spi_responder #(
  parameter int STARTING_SEED = 0,
  parameter int NUM_REGS      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic [15:0] frame_count,
  output logic        frame_error,
  output logic [31:0] last_cmd
);

  localparam logic [15:0] SEED         = STARTING_SEED[15:0];
  localparam int          AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  NUM_REGS_LIM = 9'(NUM_REGS);
  localparam logic [31:0] CMD_CLEAR    = 32'h6A00_0000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  // [0],[1] form the synchronizer, [2] is the edge-detect history flop.
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q,   cs_sync_d;
  logic [2:0]  mosi_sync_q, mosi_sync_d;

  state_e      state_q,       state_d;
  logic [5:0]  bit_cnt_q,     bit_cnt_d;
  logic [31:0] shift_in_q,    shift_in_d;
  logic [31:0] miso_sr_q,     miso_sr_d;
  logic        miso_q,        miso_d;
  logic [31:0] resp1_q,       resp1_d;
  logic [31:0] resp2_q,       resp2_d;
  logic [15:0] sweep_q,       sweep_d;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] regs_d [NUM_REGS];
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_error_q, frame_error_d;
  logic [31:0] last_cmd_q,    last_cmd_d;
  logic        start_pend_q,  start_pend_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

  // ---------------------------------------------------------------------------
  // Command decode of the captured word; only acted on in S_COMMIT.
  // ---------------------------------------------------------------------------
  logic [3:0]  ch;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        addr_ok;
  logic [15:0] rd_val;
  logic [31:0] resp_new;
  logic        do_write, sweep_inc, sweep_clr;

  assign ch      = shift_in_q[19:16];
  assign addr    = shift_in_q[23:16];
  assign data    = shift_in_q[15:0];
  assign addr_ok = {1'b0, addr} < NUM_REGS_LIM;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    resp_new  = 32'h0;
    do_write  = 1'b0;
    sweep_inc = 1'b0;
    sweep_clr = 1'b0;
    rd_val    = 16'h0;
    if (addr_ok)             rd_val = regs_q[addr[AW-1:0]];
    else if (addr == 8'hFF)  rd_val = 16'h0020;
    unique case (shift_in_q[31:30])
      2'b00: begin
        resp_new  = {SEED + {12'h000, ch} + (sweep_q << 4), 12'h000, ch};
        sweep_inc = (ch == 4'hF);
      end
      2'b10: begin
        resp_new = {16'hFFFF, data};
        do_write = addr_ok;
      end
      2'b11: resp_new = {16'h0000, rd_val};
      default: sweep_clr = (shift_in_q == CMD_CLEAR);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], SCLK};
    cs_sync_d     = {cs_sync_q[1:0], CS};
    mosi_sync_d   = {mosi_sync_q[1:0], MOSI};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_in_d    = shift_in_q;
    miso_sr_d     = miso_sr_q;
    miso_d        = miso_q;
    resp1_d       = resp1_q;
    resp2_d       = resp2_q;
    sweep_d       = sweep_q;
    regs_d        = regs_q;
    frame_count_d = frame_count_q;
    frame_error_d = 1'b0;
    last_cmd_d    = last_cmd_q;
    start_pend_d  = start_pend_q;

    unique case (state_q)
      S_IDLE: begin
        // A CS fall seen during COMMIT is remembered and started here.
        if (cs_fall || start_pend_q) begin
          state_d      = S_SHIFT;
          bit_cnt_d    = 6'd0;
          shift_in_d   = 32'h0;
          miso_d       = resp2_q[31];
          miso_sr_d    = {resp2_q[30:0], 1'b0};
          start_pend_d = 1'b0;
        end
      end
      S_SHIFT: begin
        // CS rise takes priority over a coincident SCLK edge.
        if (cs_rise) begin
          state_d = S_COMMIT;
        end else if (sclk_rise) begin
          // MOSI is taken one cycle older than the SCLK edge, still well
          // inside the window where CPHA=0 data is stable.
          shift_in_d = {shift_in_q[30:0], mosi_sync_q[2]};
          if (bit_cnt_q != 6'd33) bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (sclk_fall) begin
          // Zero fill makes MISO idle low once bit 0 has been shifted out.
          miso_d    = miso_sr_q[31];
          miso_sr_d = {miso_sr_q[30:0], 1'b0};
        end
      end
      S_COMMIT: begin
        state_d      = S_IDLE;
        start_pend_d = cs_fall;
        if (bit_cnt_q == 6'd32) begin
          resp1_d       = resp_new;
          resp2_d       = resp1_q;
          frame_count_d = frame_count_q + 16'd1;
          last_cmd_d    = shift_in_q;
          if (sweep_clr)      sweep_d = 16'h0;
          else if (sweep_inc) sweep_d = sweep_q + 16'd1;
          if (do_write) regs_d[addr[AW-1:0]] = data;
        end else begin
          frame_error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizers clear to 0: a CS held high through reset then reads as
      // a rise in IDLE, which is ignored, never as a spurious frame start.
      sclk_sync_q   <= 3'b000;
      cs_sync_q     <= 3'b000;
      mosi_sync_q   <= 3'b000;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 6'd0;
      shift_in_q    <= 32'h0;
      miso_sr_q     <= 32'h0;
      miso_q        <= 1'b0;
      resp1_q       <= 32'h0;
      resp2_q       <= 32'h0;
      sweep_q       <= 16'h0;
      frame_count_q <= 16'h0;
      frame_error_q <= 1'b0;
      last_cmd_q    <= 32'h0;
      start_pend_q  <= 1'b0;
      // NOTE: the register file is small and must read back 0 after reset,
      // so it is built from resettable flops rather than RAM.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_in_q    <= shift_in_d;
      miso_sr_q     <= miso_sr_d;
      miso_q        <= miso_d;
      resp1_q       <= resp1_d;
      resp2_q       <= resp2_d;
      sweep_q       <= sweep_d;
      frame_count_q <= frame_count_d;
      frame_error_q <= frame_error_d;
      last_cmd_q    <= last_cmd_d;
      start_pend_q  <= start_pend_d;
      regs_q        <= regs_d;
    end
  end

  assign MISO        = miso_q;
  assign frame_count = frame_count_q;
  assign frame_error = frame_error_q;
  assign last_cmd    = last_cmd_q;

endmodule

// File: tb/tb_rhs_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_rhs_spi_responder
//
// Directed bench for rhs_spi_responder (STARTING_SEED=16, NUM_REGS=16).
// clk = 100 MHz, SCLK = clk/4. A frame drives MOSI on the SCLK falling edge
// and samples MISO at the end of each SCLK high phase, which gives the
// responder's oversampling latency time to settle. The final section runs
// random frames with random phase offsets against a small reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rhs_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [15:0] frame_count;
  logic        frame_error;
  logic [31:0] last_cmd;

  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;

  rhs_spi_responder #(
    .STARTING_SEED(16),
    .NUM_REGS     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SCLK       (SCLK),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .frame_count(frame_count),
    .frame_error(frame_error),
    .last_cmd   (last_cmd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_error === 1'b1) err_pulses <= err_pulses + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state for the random section.
  logic [15:0] m_regs [16];
  logic [15:0] m_sweep;
  logic [31:0] m_r1, m_r2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #40;
  endtask

  // One SPI frame of nbits bits. With rst_mid set, reset is asserted after
  // the last bit and CS is released while reset is held.
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           input bit rst_mid, output logic [31:0] rx);
    rx = 32'h0;
    CS = 1'b0;
    #20;
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[5'(31 - i)];
      #20;
      SCLK = 1'b1;
      #20;
      rx[5'(31 - i)] = MISO;
      SCLK = 1'b0;
    end
    if (rst_mid) begin
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      CS = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else begin
      #20;
      CS = 1'b1;
    end
    MOSI = 1'b0;
    #80;
  endtask

  task automatic xfer(input string tag, input logic [31:0] word, input logic [31:0] exp_rx);
    logic [31:0] rx;
    spi_frame(word, 32, 1'b0, rx);
    check(tag, rx, exp_rx);
  endtask

  function automatic void model_step(input logic [31:0] c);
    logic [31:0] r;
    logic [7:0]  a;
    r = 32'h0;
    a = c[23:16];
    case (c[31:30])
      2'b00: begin
        r = {16'd16 + {12'h000, c[19:16]} + (m_sweep << 4), 12'h000, c[19:16]};
        if (c[19:16] == 4'hF) m_sweep = m_sweep + 16'd1;
      end
      2'b10: begin
        if (a < 8'd16) m_regs[a[3:0]] = c[15:0];
        r = {16'hFFFF, c[15:0]};
      end
      2'b11: r = {16'h0000, (a < 8'd16) ? m_regs[a[3:0]] : ((a == 8'hFF) ? 16'h0020 : 16'h0000)};
      default: begin
        if (c == 32'h6A00_0000) m_sweep = 16'h0;
        r = 32'h0;
      end
    endcase
    m_r2 = m_r1;
    m_r1 = r;
  endfunction

  localparam logic [31:0] RD255 = 32'hC0FF_0000;

  initial begin
    logic [31:0] rx;
    logic [31:0] cmd;
    int          e0;
    int          d;
    int          kind;

    rst  = 1'b1;
    SCLK = 1'b0;
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #40;

    // ---- Reset state ----
    check("rst_miso",  {31'h0, MISO}, 32'h0);
    check("rst_fc",    {16'h0, frame_count}, 32'h0);
    check("rst_ferr",  {31'h0, frame_error}, 32'h0);
    check("rst_lcmd",  last_cmd, 32'h0);

    // ---- Three CONVERTs: two-frame latency, seed offset ----
    xfer("conv_f1", 32'h0003_0000, 32'h0000_0000);
    xfer("conv_f2", 32'h0004_0000, 32'h0000_0000);
    xfer("conv_f3", 32'h0005_0000, 32'h0013_0003);
    check("conv_fc",   {16'h0, frame_count}, 32'd3);
    check("conv_lcmd", last_cmd, 32'h0005_0000);

    // ---- WRITE 2 then READ 2 ----
    xfer("wr_f1", 32'h8002_BEEF, 32'h0014_0004);
    xfer("wr_f2", 32'hC002_0000, 32'h0015_0005);
    xfer("wr_f3", RD255,         32'hFFFF_BEEF);
    xfer("wr_f4", RD255,         32'h0000_BEEF);
    xfer("wr_f5", RD255,         32'h0000_0020);
    check("wr_fc", {16'h0, frame_count}, 32'd8);

    // ---- Sweep and CLEAR ----
    for (int ch = 0; ch < 16; ch++) begin
      cmd = {12'h000, 4'(ch), 16'h0000};
      if (ch < 2) xfer("sweep0", cmd, 32'h0000_0020);
      else        xfer("sweep0", cmd, {16'(16 + ch - 2), 12'h000, 4'(ch - 2)});
    end
    xfer("sw1_conv",  32'h0000_0000, 32'h001E_000E);
    xfer("sw1_dmy1",  RD255,         32'h001F_000F);
    xfer("sw1_samp",  RD255,         32'h0020_0000);
    xfer("clr",       32'h6A00_0000, 32'h0000_0020);
    xfer("clr_conv",  32'h0000_0000, 32'h0000_0020);
    xfer("clr_dmy1",  RD255,         32'h0000_0000);
    xfer("clr_samp",  RD255,         32'h0010_0000);
    check("sweep_fc", {16'h0, frame_count}, 32'd31);

    // ---- Abort after 20 bits ----
    xfer("ab_pre1", 32'h8003_1111, 32'h0000_0020);
    xfer("ab_pre2", 32'hC002_0000, 32'h0000_0020);
    e0 = err_pulses;
    spi_frame(32'h8003_2222, 20, 1'b0, rx);
    check("ab_miso",  rx, 32'hFFFF_1000);
    check("ab_pulse", 32'(err_pulses - e0), 32'd1);
    check("ab_fc",    {16'h0, frame_count}, 32'd33);
    check("ab_lcmd",  last_cmd, 32'hC002_0000);
    xfer("ab_post1", 32'hC003_0000, 32'hFFFF_1111);
    xfer("ab_post2", RD255,         32'h0000_BEEF);
    xfer("ab_post3", RD255,         32'h0000_1111);
    check("ab_fc2",  {16'h0, frame_count}, 32'd36);

    // ---- Reset in the middle of a WRITE ----
    xfer("rm_wr1", 32'h8001_1234, 32'h0000_0020);
    e0 = err_pulses;
    spi_frame(32'h8001_5678, 12, 1'b1, rx);
    #40;
    check("rm_miso",  {31'h0, MISO}, 32'h0);
    check("rm_fc",    {16'h0, frame_count}, 32'h0);
    check("rm_ferr",  {31'h0, frame_error}, 32'h0);
    check("rm_lcmd",  last_cmd, 32'h0);
    check("rm_pulse", 32'(err_pulses - e0), 32'd0);
    xfer("rm_f1", 32'hC001_0000, 32'h0000_0000);
    xfer("rm_f2", RD255,         32'h0000_0000);
    xfer("rm_reg1", RD255,       32'h0000_0000);
    xfer("rm_f4", RD255,         32'h0000_0020);
    check("rm_fc2", {16'h0, frame_count}, 32'd4);

    // ---- Random frames, random phase, scoreboard ----
    do_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_sweep = 16'h0;
    m_r1    = 32'h0;
    m_r2    = 32'h0;
    for (int n = 0; n < 100; n++) begin
      d = $urandom_range(0, 39);
      #(d);
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        cmd = {2'b00, 2'($urandom_range(0, 3)), 4'h0, 4'($urandom_range(0, 15)), 16'h0000};
      end else if (kind == 1) begin
        cmd = {2'b10, 2'($urandom_range(0, 3)), 4'h0, 8'($urandom_range(0, 19)),
               16'($urandom)};
      end else begin
        cmd = {2'b11, 2'($urandom_range(0, 3)), 4'h0,
               ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 19)), 16'h0000};
      end
      spi_frame(cmd, 32, 1'b0, rx);
      check("rand_rx", rx, m_r2);
      model_step(cmd);
    end
    check("rand_fc",   {16'h0, frame_count}, 32'd100);
    check("rand_lcmd", last_cmd, cmd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rhs_spi_responder.md
# rhs_spi_responder

Synthesizable model of the RHS2116 SPI responder for one headstage chip, running in the fabric clock domain. It samples the SCLK, CS and MOSI lines driven by the 16-port RHS controller and decodes 32-bit CONVERT, WRITE, READ and CLEAR commands. It returns MISO responses with the chip's two-frame pipeline latency. Its targets are hardware-in-loop loopback on the FPGA and bench regression of the controller.

## Interface
- STARTING_SEED, 0: base value added to every CONVERT sample; one distinct value per port (0, 16, 32 … 240).
- NUM_REGS, 16: number of writable registers, addresses 0..NUM_REGS-1.
- clk  in  1  fabric clock; must be at least 4× the SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the controller, asynchronous to clk; CPOL=0, CPHA=0.
- CS  in  1  active-low frame select, asynchronous.
- MOSI  in  1  command data, MSB first, asynchronous.
- MISO  out  1  response data, MSB first, registered.
- frame_count  out  16  count of valid frames, wraps at 0xFFFF.
- frame_error  out  1  one-cycle pulse when a frame is aborted.
- last_cmd  out  32  most recent valid command word.

## Operation
- SCLK, CS and MOSI each pass through a 2-flop synchronizer, followed by a third flop for edge detection.
- Frame start is CS falling while the block is idle.
  - bit_cnt and shift_in are cleared.
  - The MISO shifter loads resp[n-2], and MISO drives bit 31 of it.
- On each SCLK rising edge with CS low:
  - shift_in = {shift_in[30:0], MOSI}.
  - bit_cnt increments and saturates at 33.
- On each SCLK falling edge with CS low, MISO shifts to the next lower bit. After bit 0, MISO holds 0.
- Frame end is CS rising.
  - If bit_cnt==32, the command is decoded, its response is pushed into a 2-deep pipeline (resp1←new, resp2←resp1), frame_count increments, and last_cmd updates.
  - If bit_cnt≠32, frame_error pulses and no state changes: no pipeline advance, no register write, no sample-counter change.
- Decode of cmd = shift_in:
  - CONVERT (cmd[31:30]=00):
    - ch = cmd[19:16], ch = 0..15.
    - Response is {STARTING_SEED[15:0] + ch + 16·sweep, 12'h000, ch}. Sums are modulo 2^16.
    - sweep increments after every CONVERT of ch=15.
  - WRITE (cmd[31:30]=10):
    - addr = cmd[23:16], data = cmd[15:0].
    - If addr<NUM_REGS, regs[addr]←data. Other addresses are ignored.
    - Response is {16'hFFFF, data}.
  - READ (cmd[31:30]=11):
    - Response is {16'h0000, value}.
    - value is regs[addr] for writable addresses and 16'h0020 for addr=255; every other address reads 0.
  - CLEAR (cmd==32'h6A000000):
    - sweep←0.
    - Response is 32'h00000000.
  - Any other 01-prefixed word: no state change; response is 32'h00000000.
- The U and M flags (cmd[29:28]) are accepted and ignored.
- A WRITE followed by a READ of the same address returns the new value, two frames after the READ.

## Timing
- Reset values:
  - MISO=0, frame_count=0, frame_error=0, last_cmd=0.
  - resp1=resp2=0, sweep=0, all regs=0, bit_cnt=0.
  - FSM in IDLE.
- FSM states:
  - IDLE: waits for a synchronized CS fall.
  - SHIFT: bit capture.
  - COMMIT: one cycle after CS rises; decode, pipeline push, counters.
  - COMMIT always returns to IDLE.
- Input-to-internal latency is 3 clk cycles from pad edge to detected edge. MISO changes 1 clk after the falling SCLK edge is detected.
- Simultaneous events:
  - CS rise and SCLK edge detected in the same cycle: CS wins and the edge is ignored.
  - CS fall detected during COMMIT: the frame starts on the next cycle; COMMIT is single-cycle, so no frame is lost.
- A response loaded into the MISO shifter at frame start is always resp2 as of that moment, including frames that later abort.
- rst asserted mid-frame returns the block to IDLE immediately. A partially shifted frame is discarded without a frame_error pulse.
- At wrap, frame_count 0xFFFF goes to 0x0000 with no flag.

## Test plan
- Reset, then three frames: CONVERT ch3, CONVERT ch4, CONVERT ch5, with STARTING_SEED=16.
  - MISO returns 0x00000000 in frame 1.
  - MISO returns 0x00000000 in frame 2.
  - MISO returns 0x00130003 in frame 3.
  - frame_count=3.
- WRITE addr 2 data 0xBEEF, READ 2, dummy READ 255, dummy READ 255.
  - Frame 3 returns 0xFFFFBEEF.
  - Frame 4 returns 0x0000BEEF.
  - The frame after that returns 0x00000020.
- 16 CONVERTs ch0..15, then CONVERT ch0, two dummy frames, CLEAR, CONVERT ch0, two dummy frames.
  - Sweep-1 sample = STARTING_SEED+16.
  - After CLEAR, sample = STARTING_SEED.
- CS raised after 20 bits.
  - frame_error pulses once.
  - frame_count and the pipeline are unchanged.
  - The next full frame behaves as if the aborted frame never occurred.
- Assert rst at bit 12 of a WRITE to addr 1.
  - regs[1]=0 and all outputs are at reset values.
  - The next frame is decoded normally.
- Drive clk = 4× SCLK with asynchronous phase offsets swept over 0..3 clk: 100 random CONVERT/WRITE/READ frames, all responses checked against a scoreboard model.
